// File: rtl/sphere_pixel_out.sv
// Sphere pixel output stage: delays VGA timing to match the intersection pipeline and picks the pixel colour.
// Colour updates are double-buffered and commit on the delayed vsync rising edge. Optional macro: HIT_COUNT_EN.

package graphics;
  typedef struct packed {
    logic intersects;
  } intersection_t;
endpackage

module sphere_pixel_out #(
  parameter int PIPE_LAT = 3,
  parameter int COLOR_W  = 4,
  parameter int HIT_W    = 20
) (
  input  logic                      pixel_clk,
  input  logic                      pixel_rst_n,
  input  logic                      in_de,
  input  logic                      in_hsync,
  input  logic                      in_vsync,
  input  graphics::intersection_t   intersection,
  input  logic                      color_wr,
  input  logic [3*COLOR_W-1:0]      fg_color_in,
  input  logic [3*COLOR_W-1:0]      bg_color_in,
  output logic [COLOR_W-1:0]        vga_r,
  output logic [COLOR_W-1:0]        vga_g,
  output logic [COLOR_W-1:0]        vga_b,
  output logic                      vga_hs,
  output logic                      vga_vs,
  output logic                      vga_de,
  output logic                      color_pending,
  output logic [HIT_W-1:0]          hit_count
);

  localparam int RGB_W = 3 * COLOR_W;
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [PIPE_LAT-1:0] de_sr_r;
  logic [PIPE_LAT-1:0] hs_sr_r;
  logic [PIPE_LAT-1:0] vs_sr_r;
  logic                vs_q_r;
  logic                d_de_s;
  logic                d_hs_s;
  logic                d_vs_s;
  logic                vs_rise_s;

  logic [0:0]          state_r;
  logic [0:0]          state_nxt_s;
  logic [RGB_W-1:0]    act_fg_r;
  logic [RGB_W-1:0]    act_bg_r;
  logic [RGB_W-1:0]    act_fg_nxt_s;
  logic [RGB_W-1:0]    act_bg_nxt_s;
  logic [RGB_W-1:0]    shadow_fg_r;
  logic [RGB_W-1:0]    shadow_bg_r;
  logic [RGB_W-1:0]    shadow_fg_nxt_s;
  logic [RGB_W-1:0]    shadow_bg_nxt_s;
  logic [RGB_W-1:0]    pix_s;

  assign d_de_s    = de_sr_r[PIPE_LAT-1];
  assign d_hs_s    = hs_sr_r[PIPE_LAT-1];
  assign d_vs_s    = vs_sr_r[PIPE_LAT-1];
  assign vs_rise_s = d_vs_s & ~vs_q_r;

  // Timing delay lines, aligned with the intersection result at their last tap
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      de_sr_r <= '0;
      hs_sr_r <= '0;
      vs_sr_r <= '0;
      vs_q_r  <= 1'b0;
    end else begin
      de_sr_r[0] <= in_de;
      hs_sr_r[0] <= in_hsync;
      vs_sr_r[0] <= in_vsync;
      for (int i = 1; i < PIPE_LAT; i++) begin
        de_sr_r[i] <= de_sr_r[i-1];
        hs_sr_r[i] <= hs_sr_r[i-1];
        vs_sr_r[i] <= vs_sr_r[i-1];
      end
      vs_q_r <= d_vs_s;
    end
  end

  // Colour FSM: a commit and a fresh shadow write can land in the same cycle
  always_comb begin
    state_nxt_s     = state_r;
    act_fg_nxt_s    = act_fg_r;
    act_bg_nxt_s    = act_bg_r;
    shadow_fg_nxt_s = shadow_fg_r;
    shadow_bg_nxt_s = shadow_bg_r;
    case (state_r)
      ST_IDLE: begin
        if (color_wr) begin
          shadow_fg_nxt_s = fg_color_in;
          shadow_bg_nxt_s = bg_color_in;
          state_nxt_s     = ST_PENDING;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (vs_rise_s) begin
          act_fg_nxt_s = shadow_fg_r;
          act_bg_nxt_s = shadow_bg_r;
          if (color_wr) begin
            shadow_fg_nxt_s = fg_color_in;
            shadow_bg_nxt_s = bg_color_in;
            state_nxt_s     = ST_PENDING;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (color_wr) begin
          shadow_fg_nxt_s = fg_color_in;
          shadow_bg_nxt_s = bg_color_in;
          state_nxt_s     = ST_PENDING;
        end else begin
          state_nxt_s = ST_PENDING;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Colour state registers
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_r       <= ST_IDLE;
      act_fg_r      <= '1;
      act_bg_r      <= '0;
      shadow_fg_r   <= '0;
      shadow_bg_r   <= '0;
      color_pending <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      act_fg_r      <= act_fg_nxt_s;
      act_bg_r      <= act_bg_nxt_s;
      shadow_fg_r   <= shadow_fg_nxt_s;
      shadow_bg_r   <= shadow_bg_nxt_s;
      color_pending <= (state_nxt_s == ST_PENDING);
    end
  end

  // Pixel colour select; blanking forces black regardless of the hit bit
  always_comb begin
    pix_s = '0;
    if (d_de_s) begin
      if (intersection.intersects) begin
        pix_s = act_fg_r;
      end else begin
        pix_s = act_bg_r;
      end
    end else begin
      pix_s = '0;
    end
  end

  // VGA output register
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b0;
      vga_vs <= 1'b0;
      vga_de <= 1'b0;
    end else begin
      vga_r  <= pix_s[3*COLOR_W-1 -: COLOR_W];
      vga_g  <= pix_s[2*COLOR_W-1 -: COLOR_W];
      vga_b  <= pix_s[COLOR_W-1 -: COLOR_W];
      vga_hs <= d_hs_s;
      vga_vs <= d_vs_s;
      vga_de <= d_de_s;
    end
  end

`ifdef HIT_COUNT_EN
  localparam logic [HIT_W-1:0] HIT_ONE = HIT_W'(1);

  logic [HIT_W-1:0] hit_cnt_r;
  logic [HIT_W-1:0] hit_cnt_inc_s;

  // Saturating increment; the hit in the vs_rise cycle still belongs to the closing frame
  always_comb begin
    hit_cnt_inc_s = hit_cnt_r;
    if (d_de_s && intersection.intersects && (hit_cnt_r != '1)) begin
      hit_cnt_inc_s = hit_cnt_r + HIT_ONE;
    end else begin
      hit_cnt_inc_s = hit_cnt_r;
    end
  end

  // Per-frame hit counter and latched result
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      hit_cnt_r <= '0;
      hit_count <= '0;
    end else if (vs_rise_s) begin
      hit_cnt_r <= '0;
      hit_count <= hit_cnt_inc_s;
    end else begin
      hit_cnt_r <= hit_cnt_inc_s;
    end
  end
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_sphere_pixel_out.sv
// Self-checking bench for sphere_pixel_out: directed pins plus randomized frames against a behavioural model.
module tb_sphere_pixel_out;

  localparam int PIPE_LAT = 3;
  localparam int COLOR_W  = 4;
  localparam int HIT_W    = 20;

  logic                    pixel_clk = 1'b0;
  logic                    pixel_rst_n = 1'b0;
  logic                    in_de = 1'b0;
  logic                    in_hsync = 1'b0;
  logic                    in_vsync = 1'b0;
  graphics::intersection_t intersection;
  logic                    color_wr = 1'b0;
  logic [3*COLOR_W-1:0]    fg_color_in = '0;
  logic [3*COLOR_W-1:0]    bg_color_in = '0;
  logic [COLOR_W-1:0]      vga_r, vga_g, vga_b;
  logic                    vga_hs, vga_vs, vga_de;
  logic                    color_pending;
  logic [HIT_W-1:0]        hit_count;

  sphere_pixel_out #(.PIPE_LAT(PIPE_LAT), .COLOR_W(COLOR_W), .HIT_W(HIT_W)) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n),
    .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .intersection(intersection), .color_wr(color_wr),
    .fg_color_in(fg_color_in), .bg_color_in(bg_color_in),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .color_pending(color_pending), .hit_count(hit_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  int tests = 0;
  int fails = 0;

  // Model: input history (index 0 = newest cycle), colour registers, hit tally
  bit          mh_de[5], mh_hs[5], mh_vs[5];
  logic [11:0] m_fg, m_bg, m_sfg, m_sbg;
  bit          m_pend;
  int unsigned m_cnt, m_hit;
  bit          e_de, e_hs, e_vs, e_pend;
  logic [11:0] e_rgb;
  int unsigned e_hit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      mh_de[k] = 1'b0; mh_hs[k] = 1'b0; mh_vs[k] = 1'b0;
    end
    m_fg = 12'hFFF; m_bg = 12'h000; m_sfg = 12'h000; m_sbg = 12'h000;
    m_pend = 1'b0; m_cnt = 0; m_hit = 0;
    e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_pend = 1'b0; e_rgb = 12'h000; e_hit = 0;
  endtask

  function automatic bit vs_rise_pred();
    return mh_vs[2] & ~mh_vs[3];
  endfunction

  task automatic compare();
    chk("vga_rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, e_rgb});
    chk("vga_de", {31'd0, vga_de}, {31'd0, e_de});
    chk("vga_hs", {31'd0, vga_hs}, {31'd0, e_hs});
    chk("vga_vs", {31'd0, vga_vs}, {31'd0, e_vs});
    chk("color_pending", {31'd0, color_pending}, {31'd0, e_pend});
    chk("hit_count", {12'd0, hit_count}, e_hit);
  endtask

  // One pixel cycle: check outputs, drive inputs, advance the model to the next cycle
  task automatic step(input bit de, input bit hs, input bit vs, input bit hit,
                      input bit wr, input logic [11:0] fg, input logic [11:0] bg);
    bit vs_rise;
    @(posedge pixel_clk); #1;
    compare();
    in_de = de; in_hsync = hs; in_vsync = vs; intersection.intersects = hit;
    color_wr = wr; fg_color_in = fg; bg_color_in = bg;
    for (int k = 4; k > 0; k--) begin
      mh_de[k] = mh_de[k-1]; mh_hs[k] = mh_hs[k-1]; mh_vs[k] = mh_vs[k-1];
    end
    mh_de[0] = de; mh_hs[0] = hs; mh_vs[0] = vs;
    vs_rise = mh_vs[3] & ~mh_vs[4];
    e_de = mh_de[3]; e_hs = mh_hs[3]; e_vs = mh_vs[3];
    e_rgb = !mh_de[3] ? 12'h000 : (hit ? m_fg : m_bg);
    if (mh_de[3] && hit && m_cnt != (2**HIT_W - 1)) m_cnt++;
    if (vs_rise) begin
      m_hit = m_cnt;
      m_cnt = 0;
    end
    if (vs_rise && m_pend) begin
      m_fg = m_sfg; m_bg = m_sbg; m_pend = 1'b0;
    end
    if (wr) begin
      m_sfg = fg; m_sbg = bg; m_pend = 1'b1;
    end
    e_pend = m_pend;
`ifdef HIT_COUNT_EN
    e_hit = m_hit;
`else
    e_hit = 0;
`endif
  endtask

  task automatic apply_reset();
    #2;
    pixel_rst_n = 1'b0;
    in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; intersection.intersects = 1'b0;
    color_wr = 1'b0; fg_color_in = '0; bg_color_in = '0;
    model_reset();
    #1;
    chk("rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("rst_sync", {29'd0, vga_hs, vga_vs, vga_de}, 32'd0);
    chk("rst_pending", {31'd0, color_pending}, 32'd0);
    repeat (2) @(posedge pixel_clk);
    @(negedge pixel_clk);
    pixel_rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] fg, bg;
    bit de, hs, vs, hit, wr;
    int unsigned exp_hits;
    intersection.intersects = 1'b0;
    model_reset();
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    pixel_rst_n = 1'b1;

    // Directed sequence; literal expectations pin the model
`ifdef HIT_COUNT_EN
    exp_hits = 5;
`else
    exp_hits = 0;
`endif
    for (int c = 0; c < 150; c++) begin
      de  = c inside {[20:29], 52, [66:70], 96, 116, 140};
      hs  = (c == 10);
      vs  = c inside {[60:62], [90:92], [110:112]};
      hit = c inside {[23:26], [40:45], 55, 69, 99, 119, 143};
      wr  = c inside {50, 80, 93, 130};
      fg = 12'h000; bg = 12'h000;
      if (c == 50)  begin fg = 12'hF00; bg = 12'h00F; end
      if (c == 80)  begin fg = 12'h0F0; bg = 12'h000; end
      if (c == 93)  begin fg = 12'h00F; bg = 12'h000; end
      if (c == 130) begin fg = 12'hABC; bg = 12'h123; end
      step(de, hs, vs, hit, wr, fg, bg);
      if (c == 5)   chk("lit_reset_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'h000);
      if (c == 13)  chk("lit_hs_early", {31'd0, vga_hs}, 32'd0);
      if (c == 14)  chk("lit_hs_lat4", {31'd0, vga_hs}, 32'd1);
      if (c == 15)  chk("lit_hs_end", {31'd0, vga_hs}, 32'd0);
      if (c == 23)  chk("lit_de_early", {31'd0, vga_de}, 32'd0);
      if (c == 24)  chk("lit_de_lat4", {31'd0, vga_de}, 32'd1);
      if (c == 24)  chk("lit_hit_fff", {20'd0, vga_r, vga_g, vga_b}, 32'hFFF);
      if (c == 28)  chk("lit_miss_000", {20'd0, vga_r, vga_g, vga_b}, 32'h000);
      if (c == 42)  chk("lit_blank_hit", {20'd0, vga_r, vga_g, vga_b}, 32'h000);
      if (c == 51)  chk("lit_pending_set", {31'd0, color_pending}, 32'd1);
      if (c == 56)  chk("lit_old_colour", {20'd0, vga_r, vga_g, vga_b}, 32'hFFF);
      if (c == 63)  chk("lit_vs_early", {31'd0, vga_vs}, 32'd0);
      if (c == 64)  chk("lit_vs_lat4", {31'd0, vga_vs}, 32'd1);
      if (c == 64)  chk("lit_pending_clr", {31'd0, color_pending}, 32'd0);
      if (c == 64)  chk("lit_hit_count", {12'd0, hit_count}, exp_hits);
      if (c == 70)  chk("lit_new_fg", {20'd0, vga_r, vga_g, vga_b}, 32'hF00);
      if (c == 71)  chk("lit_new_bg", {20'd0, vga_r, vga_g, vga_b}, 32'h00F);
      if (c == 81)  chk("lit_pending_2", {31'd0, color_pending}, 32'd1);
      if (c == 94)  chk("lit_collide_pend", {31'd0, color_pending}, 32'd1);
      if (c == 100) chk("lit_collide_old", {20'd0, vga_r, vga_g, vga_b}, 32'h0F0);
      if (c == 114) chk("lit_collide_clr", {31'd0, color_pending}, 32'd0);
      if (c == 120) chk("lit_collide_new", {20'd0, vga_r, vga_g, vga_b}, 32'h00F);
      if (c == 131) chk("lit_pending_3", {31'd0, color_pending}, 32'd1);
      if (c == 135) apply_reset();
      if (c == 144) chk("lit_post_rst_fg", {20'd0, vga_r, vga_g, vga_b}, 32'hFFF);
    end

    // Randomized frames: 16-pixel lines, 6 lines per frame, vsync on the last line
    for (int c = 150; c < 2550; c++) begin
      int p, x, y;
      p = (c - 150) % 96;
      x = p % 16;
      y = p / 16;
      de  = (y < 4) && (x < 10);
      hs  = (x == 12) || (x == 13);
      vs  = (y == 5);
      hit = ($urandom_range(0, 1) == 1);
      if (vs_rise_pred()) wr = ($urandom_range(0, 2) == 0);
      else                wr = ($urandom_range(0, 29) == 0);
      fg = 12'($urandom_range(0, 4095));
      bg = 12'($urandom_range(0, 4095));
      step(de, hs, vs, hit, wr, fg, bg);
      if (c == 1200) apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
